fft_stage_sequencer: RTL and testbench

//  Control sequencer for the iterative radix-2 DIT FFT datapath. On start, walks stages s=1..LOG2N.
//  Per stage: one twiddle request per butterfly offset j, then one butterfly per group k.

---
 rtl/fft_stage_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Control sequencer for an iterative radix-2 DIT FFT: walks stages, requests twiddles, issues butterflies.
// Optional bit-reverse LOAD phase before stage 1 when FFT_SEQ_BITREV_EN is defined.
module fft_stage_sequencer #(
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             tw_req,
    output logic [LOG2N-2:0] tw_idx,
    input  logic             tw_ack,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-1:0] stage,
    output logic             ld_valid,
    input  logic             ld_ready,
    output logic [LOG2N-1:0] ld_src,
    output logic [LOG2N-1:0] ld_dst
);

    localparam int W = LOG2N;
    localparam logic [W-1:0] ZERO_W    = {W{1'b0}};
    localparam logic [W-2:0] ZERO_J    = {(W-1){1'b0}};
    localparam logic [W-1:0] ONE_W     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   ONE_WP    = {{W{1'b0}}, 1'b1};
    localparam logic [W-1:0] TOP_STAGE = W'(W - 1);
    localparam logic [W:0]   N_V       = (W + 1)'(N);

`ifdef FFT_SEQ_BITREV_EN
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_LOAD = 3'd1, S_TW = 3'd2, S_BFLY = 3'd3, S_FIN = 3'd4} state_t;
    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction
`else
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_TW = 3'd2, S_BFLY = 3'd3, S_FIN = 3'd4} state_t;
`endif

    state_t        state_q;
    logic [W-1:0]  stage_q, k_q, addr_a_q, addr_b_q;
    logic [W-2:0]  j_q, tw_idx_q;
    logic          busy_q, done_q, tw_req_q, bf_valid_q;

    logic [W:0]    m_s, half_s, k_nxt_s, j_inc_s, sum_first_s, sum_cont_s, b_first_s, b_cont_s, tw_full_s;
    logic [W-1:0]  sh_s;

    // Loop-index arithmetic, computed one bit wider so k+m and j+1 never wrap
    always_comb begin
        m_s         = ONE_WP << (stage_q + ONE_W);
        half_s      = m_s >> 1;
        k_nxt_s     = {1'b0, k_q} + m_s;
        j_inc_s     = {2'b00, j_q} + ONE_WP;
        sum_first_s = {1'b0, k_q} + {2'b00, j_q};
        sum_cont_s  = k_nxt_s + {2'b00, j_q};
        b_first_s   = sum_first_s + half_s;
        b_cont_s    = sum_cont_s + half_s;
        sh_s        = TOP_STAGE - stage_q;
        tw_full_s   = j_inc_s << sh_s;
    end

`ifdef FFT_SEQ_BITREV_EN
    logic          ld_valid_q;
    logic [W-1:0]  ld_src_q, ld_dst_q, ld_inc_s;

    // Next natural-order load index
    always_comb begin
        ld_inc_s = ld_src_q + ONE_W;
    end
`endif

    // Sequencer state, loop counters and all registered outputs; abort mirrors reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            stage_q    <= ZERO_W;
            j_q        <= ZERO_J;
            k_q        <= ZERO_W;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tw_req_q   <= 1'b0;
            tw_idx_q   <= ZERO_J;
            bf_valid_q <= 1'b0;
            addr_a_q   <= ZERO_W;
            addr_b_q   <= ZERO_W;
`ifdef FFT_SEQ_BITREV_EN
            ld_valid_q <= 1'b0;
            ld_src_q   <= ZERO_W;
            ld_dst_q   <= ZERO_W;
`endif
        end else if (abort) begin
            state_q    <= S_IDLE;
            stage_q    <= ZERO_W;
            j_q        <= ZERO_J;
            k_q        <= ZERO_W;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tw_req_q   <= 1'b0;
            tw_idx_q   <= ZERO_J;
            bf_valid_q <= 1'b0;
            addr_a_q   <= ZERO_W;
            addr_b_q   <= ZERO_W;
`ifdef FFT_SEQ_BITREV_EN
            ld_valid_q <= 1'b0;
            ld_src_q   <= ZERO_W;
            ld_dst_q   <= ZERO_W;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q   <= 1'b1;
                        stage_q  <= ZERO_W;
                        j_q      <= ZERO_J;
                        k_q      <= ZERO_W;
                        tw_idx_q <= ZERO_J;
`ifdef FFT_SEQ_BITREV_EN
                        state_q    <= S_LOAD;
                        ld_valid_q <= 1'b1;
                        ld_src_q   <= ZERO_W;
                        ld_dst_q   <= ZERO_W;
`else
                        state_q  <= S_TW;
                        tw_req_q <= 1'b1;
`endif
                    end
                end
`ifdef FFT_SEQ_BITREV_EN
                S_LOAD: begin
                    if (ld_valid_q && ld_ready) begin
                        if (ld_src_q == LAST_IDX) begin
                            ld_valid_q <= 1'b0;
                            ld_src_q   <= ZERO_W;
                            ld_dst_q   <= ZERO_W;
                            state_q    <= S_TW;
                            tw_req_q   <= 1'b1;
                        end else begin
                            ld_src_q <= ld_inc_s;
                            ld_dst_q <= bit_rev(ld_inc_s);
                        end
                    end
                end
`endif
                S_TW: begin
                    if (tw_ack) begin
                        state_q    <= S_BFLY;
                        tw_req_q   <= 1'b0;
                        bf_valid_q <= 1'b1;
                        addr_a_q   <= sum_first_s[W-1:0];
                        addr_b_q   <= b_first_s[W-1:0];
                    end
                end
                S_BFLY: begin
                    if (bf_valid_q && bf_ready) begin
                        if (k_nxt_s < N_V) begin
                            k_q      <= k_nxt_s[W-1:0];
                            addr_a_q <= sum_cont_s[W-1:0];
                            addr_b_q <= b_cont_s[W-1:0];
                        end else begin
                            k_q        <= ZERO_W;
                            bf_valid_q <= 1'b0;
                            if (j_inc_s < half_s) begin
                                j_q      <= j_inc_s[W-2:0];
                                tw_idx_q <= tw_full_s[W-2:0];
                                tw_req_q <= 1'b1;
                                state_q  <= S_TW;
                            end else if (stage_q != TOP_STAGE) begin
                                stage_q  <= stage_q + ONE_W;
                                j_q      <= ZERO_J;
                                tw_idx_q <= ZERO_J;
                                tw_req_q <= 1'b1;
                                state_q  <= S_TW;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_FIN;
                            end
                        end
                    end
                end
                S_FIN: begin
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    stage_q  <= ZERO_W;
                    j_q      <= ZERO_J;
                    tw_idx_q <= ZERO_J;
                    addr_a_q <= ZERO_W;
                    addr_b_q <= ZERO_W;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign tw_req   = tw_req_q;
    assign tw_idx   = tw_idx_q;
    assign bf_valid = bf_valid_q;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign stage    = stage_q;

`ifdef FFT_SEQ_BITREV_EN
    assign ld_valid = ld_valid_q;
    assign ld_src   = ld_src_q;
    assign ld_dst   = ld_dst_q;
`else
    logic unused_ld_ready_s;
    assign unused_ld_ready_s = ld_ready;
    assign ld_valid = 1'b0;
    assign ld_src   = ZERO_W;
    assign ld_dst   = ZERO_W;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomised bench for fft_stage_sequencer against a loop-level model of the FFT schedule.
module tb_fft_stage_sequencer;
    localparam int N     = 8;
    localparam int LOG2N = 3;
`ifdef FFT_SEQ_BITREV_EN
    localparam int EXP_LAT = 29;
`else
    localparam int EXP_LAT = 21;
`endif

    logic             clk = 1'b0;
    logic             rst, start, abort, tw_ack, bf_ready, ld_ready;
    logic             busy, done, tw_req, bf_valid, ld_valid;
    logic [LOG2N-2:0] tw_idx;
    logic [LOG2N-1:0] addr_a, addr_b, stage, ld_src, ld_dst;

    fft_stage_sequencer #(.N(N), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .tw_req(tw_req), .tw_idx(tw_idx), .tw_ack(tw_ack), .bf_valid(bf_valid),
        .bf_ready(bf_ready), .addr_a(addr_a), .addr_b(addr_b), .stage(stage),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_src(ld_src), .ld_dst(ld_dst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned exp_bf[$], exp_tw[$], exp_ld[$];
    int unsigned got_bf[$], got_tw[$], got_ld[$];
    int done_cnt = 0;
    int unstable = 0;
    bit stall_en = 1'b0;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned pack_bf(int unsigned a, int unsigned b, int unsigned t, int unsigned s);
        return a * 4096 + b * 256 + t * 16 + s;
    endfunction

    // Reference schedule: stages outer, twiddle offset j middle, group k inner
    task automatic build_model();
        for (int s = 1; s <= LOG2N; s++) begin
            int m;
            m = 1 << s;
            for (int j = 0; j < m / 2; j++) begin
                int t;
                t = j << (LOG2N - s);
                exp_tw.push_back(t);
                for (int k = 0; k < N; k += m)
                    exp_bf.push_back(pack_bf(k + j, k + j + m / 2, t, s - 1));
            end
        end
        for (int i = 0; i < N; i++) begin
            int r;
            r = 0;
            for (int b = 0; b < LOG2N; b++)
                if (((i >> b) & 1) != 0) r = r | (1 << (LOG2N - 1 - b));
            exp_ld.push_back(i * 16 + r);
        end
    endtask

    // Handshake monitor and stall-stability tracker
    int unsigned prev_bf = 0, prev_tw = 0;
    bit prev_bfv = 1'b0, prev_bfacc = 1'b0, prev_twr = 1'b0, prev_twacc = 1'b0;
    always @(negedge clk) begin
        if (bf_valid && bf_ready) got_bf.push_back(pack_bf(addr_a, addr_b, tw_idx, stage));
        if (tw_req && tw_ack) got_tw.push_back(tw_idx);
        if (ld_valid && ld_ready) got_ld.push_back(ld_src * 16 + ld_dst);
        if (done) done_cnt++;
        if (prev_bfv && !prev_bfacc && bf_valid && pack_bf(addr_a, addr_b, tw_idx, stage) != prev_bf) unstable++;
        if (prev_twr && !prev_twacc && tw_req && tw_idx != prev_tw) unstable++;
        prev_bf    = pack_bf(addr_a, addr_b, tw_idx, stage);
        prev_tw    = tw_idx;
        prev_bfv   = bf_valid;
        prev_bfacc = bf_valid && bf_ready;
        prev_twr   = tw_req;
        prev_twacc = tw_req && tw_ack;
    end

    // Responder: either always ready, or ready for one cycle after a 0..5 cycle stall
    initial begin
        int bs, ts, ls;
        bs = 0; ts = 0; ls = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) begin
                if (bs > 0) begin bf_ready = 1'b0; bs--; end
                else begin bf_ready = 1'b1; bs = $urandom_range(0, 5); end
                if (ts > 0) begin tw_ack = 1'b0; ts--; end
                else begin tw_ack = 1'b1; ts = $urandom_range(0, 5); end
                if (ls > 0) begin ld_ready = 1'b0; ls--; end
                else begin ld_ready = 1'b1; ls = $urandom_range(0, 5); end
            end else begin
                bf_ready = 1'b1;
                tw_ack   = 1'b1;
                ld_ready = 1'b1;
            end
        end
    end

    task automatic compare_list(input string tag, input int unsigned exp_q[$], input int unsigned got_q[$]);
        check_eq($sformatf("%s count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, exp_q[i]);
    endtask

    task automatic run_xform(input string tag, input bit hold_start);
        int cyc;
        @(negedge clk);
        got_bf.delete(); got_tw.delete(); got_ld.delete();
        done_cnt = 0;
        unstable = 0;
        start = 1'b1;
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) start = 1'b0;
        end
        start = 1'b0;
        check_eq({tag, " done seen"}, done, 1);
        if (!stall_en) check_eq({tag, " latency"}, cyc, EXP_LAT);
        repeat (3) @(negedge clk);
        check_eq({tag, " done pulses"}, done_cnt, 1);
        check_eq({tag, " busy after"}, busy, 0);
        check_eq({tag, " stable while stalled"}, unstable, 0);
        compare_list({tag, " bf"}, exp_bf, got_bf);
        compare_list({tag, " tw"}, exp_tw, got_tw);
`ifdef FFT_SEQ_BITREV_EN
        compare_list({tag, " ld"}, exp_ld, got_ld);
`else
        check_eq({tag, " ld count"}, got_ld.size(), 0);
`endif
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        tw_ack = 1'b1; bf_ready = 1'b1; ld_ready = 1'b1;
        build_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst tw_req", tw_req, 0);
        check_eq("rst bf_valid", bf_valid, 0);
        check_eq("rst ld_valid", ld_valid, 0);
        check_eq("rst addr", {addr_a, addr_b, stage, tw_idx}, 0);
        check_eq("rst ld idx", {ld_src, ld_dst}, 0);

        run_xform("nostall", 1'b0);
        stall_en = 1'b1;
        run_xform("stall", 1'b1);
        stall_en = 1'b0;

        // Abort while issuing stage-2 butterflies
        @(negedge clk);
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(bf_valid && stage == 1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("abort reached stage2 bfly", bf_valid && stage == 1, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort busy", busy, 0);
        check_eq("abort bf_valid", bf_valid, 0);
        check_eq("abort tw_req", tw_req, 0);
        repeat (5) @(negedge clk);
        check_eq("abort no done", done_cnt, 0);
        run_xform("after abort", 1'b0);

        // Asynchronous reset while a twiddle request is pending
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!tw_req && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst reached tw", tw_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async rst busy", busy, 0);
        check_eq("async rst tw_req", tw_req, 0);
        @(negedge clk);
        rst = 1'b0;
        stall_en = 1'b1;
        run_xform("after rst", 1'b0);
        stall_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
